embedding_fetch: RTL and testbench

Parametrised embedding-row fetcher between the token front end and the MIG DDR3 application interface, replacing the per-cycle `token*16 + counter` address stepping. Accepts one token per request, issues burst read commands on the MIG app read port with a bounded number of outstanding commands, and packs returned 64-bit beats into a full embedding vector. A one-entry last-token cache answers repeated tokens without DRAM traffic. Runs in the `ui_clk` domain, sharing the read mux after `ram_init_done`.

---
 rtl/embed_pkg.sv | 21 ++
 rtl/embedding_fetch.sv | 172 +++++++++++++++++
 tb/tb_embedding_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/embed_pkg.sv
// Shared command codes, burst geometry and FSM state type for the
// embedding-row fetcher that sits on the MIG application read port.
package embed_pkg;

    localparam logic [2:0] CMD_READ          = 3'b001;
    localparam logic [2:0] CMD_WRITE         = 3'b000;
    localparam int         BEATS_PER_CMD     = 2;
    localparam int         BURST_ADDR_STRIDE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } fetch_state_e;

    // One BL8 burst on a 64-bit app port carries 128 bits of row data.
    function automatic int cmds_per_row(input int row_bits);
        return row_bits / 128;
    endfunction

endpackage

// File: rtl/embedding_fetch.sv
// Fetches one embedding row per token over the MIG app read port, packs the
// returned beats into a full vector and serves repeated tokens from a 1-entry cache.
module embedding_fetch
    import embed_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 27,
    parameter int                    APP_DATA_WIDTH  = 64,
    parameter int                    TOKEN_WIDTH     = 7,
    parameter int                    EMBED_DIM       = 16,
    parameter int                    ELEM_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            req_valid,
    input  logic [TOKEN_WIDTH-1:0]          req_token,
    output logic                            req_ready,
    output logic [ADDR_WIDTH-1:0]           ram_address,
    output logic [2:0]                      ram_cmd,
    output logic                            ram_en,
    input  logic                            ram_rdy,
    input  logic                            ram_rd_valid,
    input  logic                            ram_rd_data_end,
    input  logic [APP_DATA_WIDTH-1:0]       ram_rd_data,
    output logic                            emb_valid,
    input  logic                            emb_ready,
    output logic [EMBED_DIM*ELEM_WIDTH-1:0] emb_data,
    output logic                            emb_hit,
    output logic                            busy
);

    localparam int ROW_BITS = EMBED_DIM * ELEM_WIDTH;
    localparam int NUM_CMDS = cmds_per_row(ROW_BITS);
    localparam int BEATS    = BEATS_PER_CMD * NUM_CMDS;
    localparam int SLOTS    = ROW_BITS / APP_DATA_WIDTH;
    localparam int ISSUE_W  = $clog2(NUM_CMDS + 1);
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OUT_W    = 4;

    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE  = ADDR_WIDTH'(NUM_CMDS * BURST_ADDR_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] CMD_STRIDE  = ADDR_WIDTH'(BURST_ADDR_STRIDE);
    localparam logic [ISSUE_W-1:0]    ISSUE_LIMIT = ISSUE_W'(NUM_CMDS);
    localparam logic [OUT_W-1:0]      OUT_LIMIT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BEATS - 1);

    fetch_state_e            state_reg;
    logic [ISSUE_W-1:0]      issued_reg;
    logic [OUT_W-1:0]        outstanding_reg;
    logic [BEAT_W-1:0]       beat_cnt_reg;
    logic [ADDR_WIDTH-1:0]   cmd_addr_reg;
    logic [TOKEN_WIDTH-1:0]  token_reg;
    logic [TOKEN_WIDTH-1:0]  last_token_reg;
    logic                    cache_valid_reg;
    logic                    emb_valid_reg;
    logic                    emb_hit_reg;

    logic                    accept;
    logic                    hit;
    logic                    cmd_fire;
    logic                    beat_fire;
    logic                    end_fire;
    logic                    final_beat;
    logic [ADDR_WIDTH-1:0]   row_addr;

    assign req_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign accept      = req_valid && req_ready;
    assign hit         = cache_valid_reg && (req_token == last_token_reg) && !flush;
    assign row_addr    = BASE_ADDR + ADDR_WIDTH'(req_token) * ROW_STRIDE;

    // ram_en depends only on registered counters, so it and ram_address stay
    // put while the controller holds off with ram_rdy low.
    assign ram_en      = (state_reg == FETCH) && (issued_reg < ISSUE_LIMIT)
                         && (outstanding_reg < OUT_LIMIT);
    assign cmd_fire    = ram_en && ram_rdy;
    assign beat_fire   = (state_reg == FETCH) && ram_rd_valid;
    assign end_fire    = beat_fire && ram_rd_data_end;
    assign final_beat  = beat_fire && (beat_cnt_reg == LAST_BEAT);

    assign ram_cmd     = CMD_READ;
    assign ram_address = cmd_addr_reg;
    assign emb_valid   = emb_valid_reg;
    assign emb_hit     = emb_hit_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            issued_reg      <= '0;
            outstanding_reg <= '0;
            beat_cnt_reg    <= '0;
            cmd_addr_reg    <= '0;
            token_reg       <= '0;
            last_token_reg  <= '0;
            cache_valid_reg <= 1'b0;
            emb_valid_reg   <= 1'b0;
            emb_hit_reg     <= 1'b0;
        end else begin
            if (flush) begin
                cache_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            state_reg     <= OUT;
                            emb_valid_reg <= 1'b1;
                            emb_hit_reg   <= 1'b1;
                        end else begin
                            state_reg       <= FETCH;
                            issued_reg      <= '0;
                            outstanding_reg <= '0;
                            beat_cnt_reg    <= '0;
                            cmd_addr_reg    <= row_addr;
                            token_reg       <= req_token;
                            emb_hit_reg     <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (cmd_fire) begin
                        issued_reg   <= issued_reg + ISSUE_W'(1);
                        cmd_addr_reg <= cmd_addr_reg + CMD_STRIDE;
                    end
                    if (cmd_fire && !end_fire) begin
                        outstanding_reg <= outstanding_reg + OUT_W'(1);
                    end else if (!cmd_fire && end_fire) begin
                        outstanding_reg <= outstanding_reg - OUT_W'(1);
                    end
                    if (beat_fire) begin
                        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                    end
                    // A refill landing in the same cycle as flush wins: the
                    // row just fetched is current.
                    if (final_beat) begin
                        state_reg       <= OUT;
                        emb_valid_reg   <= 1'b1;
                        emb_hit_reg     <= 1'b0;
                        last_token_reg  <= token_reg;
                        cache_valid_reg <= 1'b1;
                    end
                end
                OUT: begin
                    if (emb_ready) begin
                        state_reg     <= IDLE;
                        emb_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Each 64-bit slot of the vector captures the beat whose arrival index matches it.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [APP_DATA_WIDTH-1:0] slot_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_reg <= '0;
            end else if (beat_fire && (beat_cnt_reg == BEAT_W'(gi))) begin
                slot_reg <= ram_rd_data;
            end
        end

        assign emb_data[gi*APP_DATA_WIDTH +: APP_DATA_WIDTH] = slot_reg;
    end

endmodule

// File: tb/tb_embedding_fetch.sv
// Scoreboard bench for embedding_fetch: a MIG read-port model answers commands,
// a negedge monitor checks every vector handshake against the expected queue.
module tb_embedding_fetch;
    import embed_pkg::*;

    localparam int AW    = 27;
    localparam int DW    = 64;
    localparam int TW    = 7;
    localparam int DIM   = 16;
    localparam int EW    = 32;
    localparam int MAXO  = 2;
    localparam int NCMD  = 4;
    localparam int NBEAT = 8;
    localparam int VW    = DIM * EW;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            req_valid;
    logic [TW-1:0]   req_token;
    logic            req_ready;
    logic [AW-1:0]   ram_address;
    logic [2:0]      ram_cmd;
    logic            ram_en;
    logic            ram_rdy;
    logic            ram_rd_valid;
    logic            ram_rd_data_end;
    logic [DW-1:0]   ram_rd_data;
    logic            emb_valid;
    logic            emb_ready;
    logic [VW-1:0]   emb_data;
    logic            emb_hit;
    logic            busy;

    always #5 clk = ~clk;

    embedding_fetch #(
        .ADDR_WIDTH      (AW),
        .APP_DATA_WIDTH  (DW),
        .TOKEN_WIDTH     (TW),
        .EMBED_DIM       (DIM),
        .ELEM_WIDTH      (EW),
        .BASE_ADDR       ('0),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_token       (req_token),
        .req_ready       (req_ready),
        .ram_address     (ram_address),
        .ram_cmd         (ram_cmd),
        .ram_en          (ram_en),
        .ram_rdy         (ram_rdy),
        .ram_rd_valid    (ram_rd_valid),
        .ram_rd_data_end (ram_rd_data_end),
        .ram_rd_data     (ram_rd_data),
        .emb_valid       (emb_valid),
        .emb_ready       (emb_ready),
        .emb_data        (emb_data),
        .emb_hit         (emb_hit),
        .busy            (busy)
    );

    typedef struct {
        logic [VW-1:0] data;
        logic          hit;
    } emb_exp_t;

    int            total  = 0;
    int            passed = 0;
    logic [AW-1:0] exp_cmd_q[$];
    emb_exp_t      exp_emb_q[$];
    int            pend_due_q[$];
    logic [DW-1:0] data_base  = 64'h0;
    int            resp_delay = 1;
    int            stall_cmd  = -1;
    int            stall_left = 0;
    logic [AW-1:0] stall_addr = '0;
    logic [VW-1:0] last_vec   = '0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MIG read-port model: decides ram_rdy, records accepted commands and
    // returns two beats per command resp_delay cycles after acceptance.
    initial begin : mem_model
        int   cyc;
        int   out_cnt;
        int   beat_seq;
        int   cmd_idx;
        bit   phase;
        bit   end_prev;
        bit   final_prev;
        bit   end_now;
        bit   final_now;
        cyc = 0; out_cnt = 0; beat_seq = 0; cmd_idx = 0;
        phase = 0; end_prev = 0; final_prev = 0;
        ram_rdy = 1'b1; ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0; ram_rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            end_now   = 0;
            final_now = 0;
            if (reset) begin
                pend_due_q.delete();
                out_cnt = 0; beat_seq = 0; cmd_idx = 0; phase = 0;
                ram_rdy = 1'b1; ram_rd_valid = 1'b0; ram_rd_data_end = 1'b0;
            end else begin
                if (end_prev && exp_cmd_q.size() > 0)
                    check("issue_resume_after_end", VW'(ram_en), VW'(1'b1));
                if (final_prev)
                    check("emb_valid_after_last_beat", VW'(emb_valid), VW'(1'b1));

                ram_rdy = 1'b1;
                if (ram_en && cmd_idx == stall_cmd && stall_left > 0) begin
                    ram_rdy = 1'b0;
                    stall_left--;
                    check("stall_en_held", VW'(ram_en), VW'(1'b1));
                    check("stall_addr_held", VW'(ram_address), VW'(stall_addr));
                end

                if (ram_en && ram_rdy) begin
                    check("cmd_type", VW'(ram_cmd), VW'(CMD_READ));
                    if (exp_cmd_q.size() == 0) begin
                        total++;
                        $display("FAIL cmd_unexpected: got command at %0h expected none", ram_address);
                    end else begin
                        check("cmd_addr", VW'(ram_address), VW'(exp_cmd_q.pop_front()));
                    end
                    pend_due_q.push_back(cyc + resp_delay);
                    out_cnt++;
                    cmd_idx++;
                    check("outstanding_bound", VW'(out_cnt <= MAXO), VW'(1'b1));
                end

                ram_rd_valid    = 1'b0;
                ram_rd_data_end = 1'b0;
                if (phase) begin
                    ram_rd_valid    = 1'b1;
                    ram_rd_data_end = 1'b1;
                    ram_rd_data     = data_base + 64'(beat_seq);
                    beat_seq++;
                    phase   = 0;
                    end_now = 1;
                    out_cnt--;
                    if (beat_seq == NBEAT) begin
                        final_now = 1;
                        beat_seq  = 0;
                        cmd_idx   = 0;
                    end
                end else if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
                    void'(pend_due_q.pop_front());
                    ram_rd_valid = 1'b1;
                    ram_rd_data  = data_base + 64'(beat_seq);
                    beat_seq++;
                    phase = 1;
                end
            end
            end_prev   = end_now;
            final_prev = final_now;
        end
    end

    // Output monitor: compares each handshaken vector with the scoreboard and
    // checks that a stalled vector does not move.
    initial begin : emb_monitor
        bit            held_v;
        logic [VW-1:0] held_d;
        logic          held_h;
        emb_exp_t      e;
        held_v = 0; held_d = '0; held_h = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 0;
            end else if (emb_valid) begin
                check("req_ready_low_in_out", VW'(req_ready), VW'(1'b0));
                if (held_v) begin
                    check("emb_data_stable", emb_data, held_d);
                    check("emb_hit_stable", VW'(emb_hit), VW'(held_h));
                end
                if (emb_ready) begin
                    if (exp_emb_q.size() == 0) begin
                        total++;
                        $display("FAIL emb_unexpected: got vector %0h expected none", emb_data);
                    end else begin
                        e = exp_emb_q.pop_front();
                        check("emb_data", emb_data, e.data);
                        check("emb_hit", VW'(emb_hit), VW'(e.hit));
                        $display("txn: vector hit=%0b slot0=%0h slot7=%0h", emb_hit,
                                 emb_data[0 +: 64], emb_data[7*64 +: 64]);
                    end
                    held_v = 0;
                end else begin
                    held_v = 1;
                    held_d = emb_data;
                    held_h = emb_hit;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int tok, input bit exp_hit, input logic [DW-1:0] base, input int delay);
        logic [VW-1:0] v;
        int            n;
        if (!exp_hit) begin
            for (int c = 0; c < NCMD; c++) exp_cmd_q.push_back(AW'(tok * 32 + 8 * c));
            for (int k = 0; k < NBEAT; k++) v[k*64 +: 64] = base + 64'(k);
            last_vec   = v;
            data_base  = base;
            resp_delay = delay;
        end else begin
            v = last_vec;
        end
        exp_emb_q.push_back('{data: v, hit: exp_hit});
        req_token = TW'(tok);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check("req_accepted", VW'(req_ready), VW'(1'b1));
        tick();
        req_valid = 1'b0;
        $display("txn: request token=%0d hit_expected=%0b", tok, exp_hit);
        if (exp_hit) begin
            check("hit_valid_next_cycle", VW'(emb_valid), VW'(1'b1));
            check("hit_flag_next_cycle", VW'(emb_hit), VW'(1'b1));
            check("hit_no_ram_en", VW'(ram_en), VW'(1'b0));
        end else begin
            check("miss_first_en_next_cycle", VW'(ram_en), VW'(1'b1));
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_emb_q.size() > 0 || busy) && n < 1000) begin
            tick();
            n++;
        end
        check("txn_complete", VW'(exp_emb_q.size() == 0 && !busy), VW'(1'b1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, VW'(req_ready), VW'(1'b1));
        check({tag, "_ram_en"}, VW'(ram_en), VW'(1'b0));
        check({tag, "_ram_cmd"}, VW'(ram_cmd), VW'(3'b001));
        check({tag, "_ram_address"}, VW'(ram_address), VW'(0));
        check({tag, "_emb_valid"}, VW'(emb_valid), VW'(1'b0));
        check({tag, "_emb_hit"}, VW'(emb_hit), VW'(1'b0));
        check({tag, "_busy"}, VW'(busy), VW'(1'b0));
        check({tag, "_emb_data"}, emb_data, VW'(0));
    endtask

    initial begin : stimulus
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_token = '0; emb_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Token 5 miss: commands 160..184, beats A000+k.
        fetch(5, 1'b0, 64'hA000, 2);
        wait_done();

        // Same token again: cache hit, no DRAM traffic.
        fetch(5, 1'b1, 64'h0, 1);
        for (int i = 0; i < 3; i++) begin
            check("hit_idle_ram_en", VW'(ram_en), VW'(1'b0));
            tick();
        end
        wait_done();

        // Flush, then token 5 misses; command 1 (address 168) held off 3 cycles.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall_cmd  = 1;
        stall_left = 3;
        stall_addr = AW'(168);
        fetch(5, 1'b0, 64'hC000, 1);
        wait_done();
        check("stall_cycles_consumed", VW'(stall_left), VW'(0));
        stall_cmd = -1;

        // Token 3 with 10-cycle read latency exercises the outstanding limit.
        fetch(3, 1'b0, 64'hD000, 10);
        wait_done();

        // Hit on token 3 with the consumer stalled for 5 cycles.
        emb_ready = 1'b0;
        fetch(3, 1'b1, 64'h0, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_emb_valid_held", VW'(emb_valid), VW'(1'b1));
            check("stall_req_ready_low", VW'(req_ready), VW'(1'b0));
            tick();
        end
        emb_ready = 1'b1;
        wait_done();

        // Reset in the middle of a fetch of token 10.
        fetch(10, 1'b0, 64'hE000, 10);
        repeat (3) tick();
        check("mid_fetch_busy", VW'(busy), VW'(1'b1));
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        exp_cmd_q.delete();
        exp_emb_q.delete();
        tick();
        reset = 1'b0;
        tick();

        // Cache was invalidated by reset: token 5 misses again.
        fetch(5, 1'b0, 64'hF000, 1);
        wait_done();

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
